// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and RV32I opcode/funct constants.
// Used by the issue stage, the ALU and their benches.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSll  = 4'b0010,
    AluSlt  = 4'b0100,
    AluSltu = 4'b0110,
    AluXor  = 4'b1000,
    AluSrl  = 4'b1010,
    AluSra  = 4'b1011,
    AluOr   = 4'b1100,
    AluAnd  = 4'b1110
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between register-read, the issue stage and execute.
// slave is the issue stage's view; master is the surrounding pipeline's view.
interface alu_issue_stage_if #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned N_REGS = 32
);
  localparam int unsigned N_IDX = $clog2(N_REGS);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [N_BITS-1:0] in_pc;
  logic [N_BITS-1:0] in_rs1_val;
  logic [N_BITS-1:0] in_rs2_val;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_alu_op;
  logic [N_BITS-1:0] out_in0;
  logic [N_BITS-1:0] out_in1;
  logic [N_IDX-1:0]  out_rd;
  logic              out_rd_we;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_alu_op, out_in0, out_in1, out_rd, out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_alu_op, out_in0, out_in1, out_rd, out_rd_we, out_illegal
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered ready and synchronous flush.
// Output is always taken from the main entry; the skid entry absorbs one beat of backpressure.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             pop;

  assign accept = valid_i & ready_q;
  assign pop    = (state_q != StEmpty) & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = data_i;
          end
        end
        StOne: begin
          if (accept && !ready_i) begin
            state_d = StFull;
            skid_d  = data_i;
          end else if (accept) begin
            main_d = data_i;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // ready_q is low here, so no accept can coincide with the pop
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = (state_q != StEmpty);
  assign data_o  = main_q;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU op and operands,
// then buffers the decoded result through a two-entry skid buffer toward execute.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned N_REGS = 32
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  alu_issue_stage_if.slave  bus
);

  localparam int unsigned N_IDX = $clog2(N_REGS);

  typedef struct packed {
    logic [3:0]        alu_op;
    logic [N_BITS-1:0] in0;
    logic [N_BITS-1:0] in1;
    logic [N_IDX-1:0]  rd;
    logic              rd_we;
    logic              illegal;
  } payload_t;

  function automatic payload_t decode(input logic [31:0]       instr,
                                      input logic [N_BITS-1:0] pc,
                                      input logic [N_BITS-1:0] rs1,
                                      input logic [N_BITS-1:0] rs2);
    payload_t   p;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       legal;
    p      = '0;
    f7     = instr[31:25];
    f3     = instr[14:12];
    legal  = 1'b0;
    p.alu_op = AluAdd;
    p.rd     = N_IDX'(instr[11:7]);
    case (instr[6:0])
      OPC_OP: begin
        legal    = (f7 == 7'd0) || (f7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        p.alu_op = {f3, instr[30]};
        p.in0    = rs1;
        p.in1    = rs2;
      end
      OPC_OP_IMM: begin
        p.in0 = rs1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediates reuse the upper immediate bits as funct7
          legal    = (f7 == 7'd0) || (f7 == FUNCT7_ALT && f3 == 3'b101);
          p.alu_op = {f3, f3[2] & instr[30]};
          p.in1    = N_BITS'(instr[24:20]);
        end else begin
          legal    = 1'b1;
          p.alu_op = {f3, 1'b0};
          p.in1    = N_BITS'($signed(instr[31:20]));
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        p.in1 = N_BITS'($signed({instr[31:12], 12'h000}));
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        p.in0 = pc;
        p.in1 = N_BITS'($signed({instr[31:12], 12'h000}));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      p.alu_op = AluAdd;
      p.in0    = '0;
      p.in1    = '0;
    end
    p.illegal = !legal;
    p.rd_we   = legal && (instr[11:7] != 5'd0);
    return p;
  endfunction

  payload_t in_payload;
  payload_t out_payload;

  assign in_payload = decode(bus.in_instr, bus.in_pc, bus.in_rs1_val, bus.in_rs2_val);

  skid_buffer #(
    .WIDTH($bits(payload_t))
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .valid_i (bus.in_valid),
    .ready_o (bus.in_ready),
    .data_i  (in_payload),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (out_payload)
  );

  assign bus.out_alu_op  = out_payload.alu_op;
  assign bus.out_in0     = out_payload.in0;
  assign bus.out_in1     = out_payload.in1;
  assign bus.out_rd      = out_payload.rd;
  assign bus.out_rd_we   = out_payload.rd_we;
  assign bus.out_illegal = out_payload.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.N_BITS(32), .N_REGS(32)) bus ();

  alu_issue_stage #(
    .N_BITS(32),
    .N_REGS(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   m_rdy    = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, by mnemonic class.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    bit         ok;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    f7    = ins[31:25];
    f3    = ins[14:12];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_u = {ins[31:12], 12'h000};
    e.rd  = ins[11:7];
    e.op  = 4'b0000;
    e.in0 = 32'd0;
    e.in1 = 32'd0;
    ok    = 1'b0;
    if (ins[6:0] == 7'h33) begin
      ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op  = {f3, (f7 == 7'h20)};
      e.in0 = a;
      e.in1 = b;
    end else if (ins[6:0] == 7'h13) begin
      e.in0 = a;
      if (f3 == 3'd1) begin
        ok    = (f7 == 7'h00);
        e.op  = 4'b0010;
        e.in1 = {27'd0, ins[24:20]};
      end else if (f3 == 3'd5) begin
        ok    = (f7 == 7'h00) || (f7 == 7'h20);
        e.op  = (f7 == 7'h20) ? 4'b1011 : 4'b1010;
        e.in1 = {27'd0, ins[24:20]};
      end else begin
        ok    = 1'b1;
        e.op  = {f3, 1'b0};
        e.in1 = imm_i;
      end
    end else if (ins[6:0] == 7'h37) begin
      ok    = 1'b1;
      e.in1 = imm_u;
    end else if (ins[6:0] == 7'h17) begin
      ok    = 1'b1;
      e.in0 = pc;
      e.in1 = imm_u;
    end
    if (!ok) begin
      e.op  = 4'b0000;
      e.in0 = 32'd0;
      e.in1 = 32'd0;
    end
    e.ill = !ok;
    e.we  = ok && (e.rd != 5'd0);
    return e;
  endfunction

  // Compare, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    exp_t n;
    bit   acc;
    bit   pop;
    if (!rst_n) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      chk("out_valid", bus.out_valid, q.size() > 0);
      chk("in_ready", bus.in_ready, m_rdy);
      if (q.size() > 0) begin
        chk("alu_op", bus.out_alu_op, q[0].op);
        chk("in0", bus.out_in0, q[0].in0);
        chk("in1", bus.out_in1, q[0].in1);
        chk("rd", bus.out_rd, q[0].rd);
        chk("rd_we", bus.out_rd_we, q[0].we);
        chk("illegal", bus.out_illegal, q[0].ill);
      end
      acc = bus.in_valid && m_rdy;
      pop = (q.size() > 0) && bus.out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (acc) n = model(bus.in_instr, bus.in_pc, bus.in_rs1_val, bus.in_rs2_val);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(n);
      end
      m_rdy = (q.size() < 2);
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.in_instr   = ins;
    bus.in_pc      = pc;
    bus.in_rs1_val = a;
    bus.in_rs2_val = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int unsigned r;
    w = $urandom;
    r = $urandom_range(0, 3);
    f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom);
    case ($urandom_range(0, 5))
      0:       w = {f7, w[24:7], 7'h33};
      1:       w = {w[31:7], 7'h13};
      2:       w = {w[31:7], 7'h37};
      3:       w = {w[31:7], 7'h17};
      4:       w = {f7, w[24:15], (w[14] ? 3'd5 : 3'd1), w[11:7], 7'h13};
      default: w = w;
    endcase
    return w;
  endfunction

  initial begin
    exp_t m;
    bus.in_valid   = 1'b0;
    bus.in_instr   = 32'd0;
    bus.in_pc      = 32'd0;
    bus.in_rs1_val = 32'd0;
    bus.in_rs2_val = 32'd0;
    bus.out_ready  = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_in1", bus.out_in1, 32'd0);
    chk("reset_rd_we", bus.out_rd_we, 1'b0);

    // Pin the model itself against hand-computed decodes.
    m = model(32'h002081B3, 32'd0, 32'd5, 32'd7);
    chk("model_add", {m.op, m.in0, m.in1[15:0], m.rd, m.we, m.ill},
        {4'b0000, 32'd5, 16'd7, 5'd3, 1'b1, 1'b0});
    m = model(32'h40335293, 32'd0, 32'h80000000, 32'd0);
    chk("model_srai", {m.op, m.in1}, {4'b1011, 32'd3});
    m = model(32'h00000000, 32'd0, 32'd1, 32'd2);
    chk("model_illegal", {m.ill, m.we, m.in0}, {1'b1, 1'b0, 32'd0});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'h002081B3, 32'd0, 32'd5, 32'd7);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_op", bus.out_alu_op, 4'b0000);
    chk("add_in0", bus.out_in0, 32'd5);
    chk("add_in1", bus.out_in1, 32'd7);
    chk("add_rd", bus.out_rd, 5'd3);
    chk("add_we", bus.out_rd_we, 1'b1);

    send(32'h40335293, 32'd0, 32'h80000000, 32'd0);
    chk("srai_op", bus.out_alu_op, 4'b1011);
    chk("srai_in1", bus.out_in1, 32'h00000003);
    chk("srai_rd", bus.out_rd, 5'd5);

    send(32'hABCDE0B7, 32'd0, 32'd9, 32'd9);
    chk("lui_in0", bus.out_in0, 32'd0);
    chk("lui_in1", bus.out_in1, 32'hABCDE000);
    chk("lui_op", bus.out_alu_op, 4'b0000);

    send(32'hABCDE097, 32'h100, 32'd9, 32'd9);
    chk("auipc_in0", bus.out_in0, 32'h100);
    chk("auipc_in1", bus.out_in1, 32'hABCDE000);

    send(32'h00000000, 32'd0, 32'd1, 32'd2);
    chk("zero_illegal", bus.out_illegal, 1'b1);
    chk("zero_we", bus.out_rd_we, 1'b0);

    send(32'h00208033, 32'd0, 32'd1, 32'd2);
    chk("x0_illegal", bus.out_illegal, 1'b0);
    chk("x0_we", bus.out_rd_we, 1'b0);
    idle_cycle();

    // Backpressure: two accepted, third held, then all three drain in order.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'd0, 32'd1, 32'd0);
    chk("bp_ready_one", bus.in_ready, 1'b1);
    send(32'h002081B3, 32'd0, 32'd2, 32'd0);
    chk("bp_ready_full", bus.in_ready, 1'b0);
    chk("bp_head", bus.out_in0, 32'd1);
    send(32'h002081B3, 32'd0, 32'd3, 32'd0);
    chk("bp_held_ready", bus.in_ready, 1'b0);
    chk("bp_stable", bus.out_in0, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second", bus.out_in0, 32'd2);
    chk("bp_ready_back", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_third", bus.out_in0, 32'd3);
    idle_cycle();
    chk("bp_drained", bus.out_valid, 1'b0);

    // Flush in FULL with a live input: everything dropped.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'd0, 32'd4, 32'd0);
    send(32'h002081B3, 32'd0, 32'd5, 32'd0);
    flush = 1'b1;
    send(32'h002081B3, 32'd0, 32'd6, 32'd0);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ready", bus.in_ready, 1'b1);
    flush = 1'b0;
    idle_cycle();
    chk("flush_dropped", bus.out_valid, 1'b0);

    // Asynchronous reset with the buffer full.
    send(32'h002081B3, 32'd0, 32'd7, 32'd0);
    send(32'h002081B3, 32'd0, 32'd8, 32'd0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_ready", bus.in_ready, 1'b1);
    chk("arst_in0", bus.out_in0, 32'd0);
    chk("arst_rd", bus.out_rd, 5'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_instr   = rand_instr();
      bus.in_pc      = $urandom;
      bus.in_rs1_val = $urandom;
      bus.in_rs2_val = $urandom;
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
